// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the show-ahead synchronous FIFO.
// The status flags are derived from the occupancy count alone.
package sync_fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic half_full;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Written as count + 2 >= depth so small depths cannot underflow.
    function automatic fifo_flags_t fifo_flags(input int unsigned count,
                                               input int unsigned depth);
        fifo_flags_t f;
        f.full         = (count == depth);
        f.empty        = (count == 0);
        f.half_full    = (count >= depth / 2);
        f.almost_full  = (count + 2 >= depth);
        f.almost_empty = (count <= 1);
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DBITS register array: one synchronous write port, one asynchronous read port.
// Storage has no reset; only the pointers in the parent define which words are valid.
module sync_fifo_ram #(
    parameter int unsigned DBITS = 32,
    parameter int unsigned SIZE  = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [SIZE-1:0]  waddr_i,
    input  logic [DBITS-1:0] wdata_i,
    input  logic [SIZE-1:0]  raddr_i,
    output logic [DBITS-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << SIZE;

    logic [DBITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with count-derived status flags.
// Pointers wrap modulo DEPTH; count disambiguates full from empty.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DBITS = 32,
    parameter int unsigned SIZE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] din,
    input  logic             wr,
    input  logic             rd,
    output logic [DBITS-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             half_full,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int unsigned DEPTH = 1 << SIZE;
    localparam logic [SIZE-1:0] PtrOne = 1;
    localparam logic [SIZE:0]   CntOne = 1;

    logic [SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [SIZE:0]   count_q, count_d;
    logic            wr_en, rd_en;
    fifo_flags_t     flags;

    assign flags        = fifo_flags(32'(count_q), DEPTH);
    assign full         = flags.full;
    assign empty        = flags.empty;
    assign half_full    = flags.half_full;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;

    // Gating on the registered flags makes wr+rd at full a pure pop and at empty a pure push.
    assign wr_en = wr && !flags.full;
    assign rd_en = rd && !flags.empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + CntOne;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CntOne;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    sync_fifo_ram #(
        .DBITS (DBITS),
        .SIZE  (SIZE)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .raddr_i (rd_ptr_q),
        .rdata_o (dout)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

    localparam int unsigned DBITS = 32;
    localparam int unsigned DEPTH = 16;

    logic             clk;
    logic             reset;
    logic [DBITS-1:0] din;
    logic             wr;
    logic             rd;
    logic [DBITS-1:0] dout;
    logic             full;
    logic             empty;
    logic             half_full;
    logic             almost_full;
    logic             almost_empty;

    logic [DBITS-1:0] model_q [$];
    int unsigned      n_checks;
    int unsigned      n_pass;

    sync_fifo #(
        .DBITS (DBITS),
        .SIZE  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .wr           (wr),
        .rd           (rd),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .half_full    (half_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string ctx);
        int unsigned n;
        n = model_q.size();
        check({ctx, ".empty"},        64'(empty),        64'(n == 0));
        check({ctx, ".full"},         64'(full),         64'(n == DEPTH));
        check({ctx, ".half_full"},    64'(half_full),    64'(n >= DEPTH / 2));
        check({ctx, ".almost_full"},  64'(almost_full),  64'(n >= DEPTH - 2));
        check({ctx, ".almost_empty"}, 64'(almost_empty), 64'(n <= 1));
        if (n != 0) begin
            check({ctx, ".dout"}, 64'(dout), 64'(model_q[0]));
        end
    endtask

    // Called at a negedge; drives one cycle, updates the model at the edge, checks after.
    task automatic step(input string ctx, input logic w, input logic r,
                        input logic [DBITS-1:0] d);
        bit w_acc, r_acc;
        wr  = w;
        rd  = r;
        din = d;
        @(posedge clk);
        w_acc = w && (model_q.size() < DEPTH);
        r_acc = r && (model_q.size() > 0);
        if (r_acc) void'(model_q.pop_front());
        if (w_acc) model_q.push_back(d);
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
        check_state(ctx);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        wr       = 1'b0;
        rd       = 1'b0;
        din      = '0;
        repeat (2) @(negedge clk);
        check_state("rst");
        reset = 1'b1;
        @(negedge clk);
        check_state("idle");
        step("rd_empty", 1'b0, 1'b1, 32'h0);
        step("rd_empty", 1'b0, 1'b1, 32'h0);

        step("single_wr", 1'b1, 1'b0, 32'hDEADBEEF);
        check("single_dout", 64'(dout), 64'h0000_0000_DEAD_BEEF);
        step("single_rd", 1'b0, 1'b1, 32'h0);
        check("single_empty", 64'(empty), 64'd1);

        for (int i = 1; i <= 16; i++) begin
            step("fill", 1'b1, 1'b0, 32'(i));
            if (i == 8)  check("fill_half8", 64'(half_full), 64'd1);
            if (i == 13) check("fill_af13", 64'(almost_full), 64'd0);
            if (i == 14) check("fill_af14", 64'(almost_full), 64'd1);
        end
        check("fill_full", 64'(full), 64'd1);
        step("fill_over", 1'b1, 1'b0, 32'hFF);
        for (int i = 1; i <= 16; i++) begin
            check("drain_order", 64'(dout), 64'(i));
            step("drain", 1'b0, 1'b1, 32'h0);
        end
        check("drain_empty", 64'(empty), 64'd1);

        for (int i = 0; i < 10; i++) step("wrap_w10", 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 10; i++) step("wrap_r10", 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 12; i++) step("wrap_w12", 1'b1, 1'b0, 32'h100 + 32'(i));
        for (int i = 0; i < 12; i++) begin
            check("wrap_seq", 64'(dout), 64'(32'h100 + 32'(i)));
            step("wrap_r12", 1'b0, 1'b1, 32'h0);
        end

        for (int i = 0; i < 5; i++) step("sim_pre", 1'b1, 1'b0, 32'h200 + 32'(i));
        for (int i = 0; i < 4; i++) step("sim_rw", 1'b1, 1'b1, 32'h300 + 32'(i));
        check("sim_cnt5_ae", 64'(almost_empty), 64'd0);
        check("sim_cnt5_hf", 64'(half_full), 64'd0);
        check("sim_head", 64'(dout), 64'h204);
        while (model_q.size() < DEPTH) step("sim_fill", 1'b1, 1'b0, $urandom);
        step("sim_full_rw", 1'b1, 1'b1, 32'hAAAA_AAAA);
        check("sim_full_drop", 64'(full), 64'd0);
        while (model_q.size() > 0) step("sim_drain", 1'b0, 1'b1, 32'h0);
        step("sim_empty_rw", 1'b1, 1'b1, 32'h77);
        check("sim_empty_dout", 64'(dout), 64'h77);
        step("sim_empty_pop", 1'b0, 1'b1, 32'h0);

        for (int i = 0; i < 9; i++) step("rst_pre", 1'b1, 1'b0, 32'h400 + 32'(i));
        #2 reset = 1'b0;
        model_q.delete();
        #1 check_state("rst_async");
        #1 reset = 1'b1;
        @(negedge clk);
        check_state("rst_after");
        step("rst_w55", 1'b1, 1'b0, 32'h55);
        check("rst_head", 64'(dout), 64'h55);

        for (int i = 0; i < 3000; i++) begin
            int unsigned wbias;
            wbias = ((i / 250) % 2 == 0) ? 70 : 30;
            step("rand", ($urandom_range(0, 99) < wbias), ($urandom_range(0, 99) < 50), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
